// File: rtl/i2c_tx_shifter.sv
// ============================================================================
// i2c_tx_shifter : I2C slave transmit shifter with one-deep holding buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_tx_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  load_data,
    output logic                  load_ready,
    input  logic                  falling_edge_found,
    input  logic                  rising_edge_found,
    input  logic                  sda_in,
    input  logic                  clear,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  byte_sent,
    output logic                  ack_received,
    output logic                  nack_received
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        ACK_WAIT = 2'd2,
        ACK_HOLD = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_n;
    logic [DATA_WIDTH-1:0]   pending, pending_n;
    logic                    pending_valid, pending_valid_n;
    logic [CNT_W-1:0]        bit_cnt, bit_cnt_n;
    logic                    ack_ok, ack_ok_n;
    logic                    byte_sent_n, ack_n, nack_n;
    logic                    accept;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            shift_reg     <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            bit_cnt       <= '0;
            ack_ok        <= 1'b0;
            tx_out        <= 1'b1;
            busy          <= 1'b0;
            load_ready    <= 1'b1;
            byte_sent     <= 1'b0;
            ack_received  <= 1'b0;
            nack_received <= 1'b0;
        end else begin
            state         <= state_n;
            shift_reg     <= shift_n;
            pending       <= pending_n;
            pending_valid <= pending_valid_n;
            bit_cnt       <= bit_cnt_n;
            ack_ok        <= ack_ok_n;
            // Outputs are registered from next-state values so data appears the cycle after the event
            tx_out        <= (state_n == SHIFT) ? shift_n[DATA_WIDTH-1] : 1'b1;
            busy          <= (state_n != IDLE);
            load_ready    <= !pending_valid_n;
            byte_sent     <= byte_sent_n;
            ack_received  <= ack_n;
            nack_received <= nack_n;
        end
    end

    assign accept = load_data && load_ready && !clear;

    always_comb begin
        state_n         = state;
        shift_n         = shift_reg;
        pending_n       = pending;
        pending_valid_n = pending_valid;
        bit_cnt_n       = bit_cnt;
        ack_ok_n        = ack_ok;
        byte_sent_n     = 1'b0;
        ack_n           = 1'b0;
        nack_n          = 1'b0;

        case (state)
            IDLE: begin
                if (pending_valid) begin
                    shift_n         = pending;
                    pending_valid_n = 1'b0;
                    state_n         = SHIFT;
                end
            end
            SHIFT: begin
                if (falling_edge_found) begin
                    shift_n = {shift_reg[DATA_WIDTH-2:0], 1'b1};
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_n   = '0;
                        byte_sent_n = 1'b1;
                        state_n     = ACK_WAIT;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            ACK_WAIT: begin
                if (rising_edge_found && !falling_edge_found) begin
                    ack_n    = !sda_in;
                    nack_n   = sda_in;
                    ack_ok_n = !sda_in;
                    state_n  = ACK_HOLD;
                end
            end
            ACK_HOLD: begin
                if (falling_edge_found) begin
                    if (ack_ok && pending_valid) begin
                        shift_n         = pending;
                        pending_valid_n = 1'b0;
                        state_n         = SHIFT;
                    end else begin
                        // NACK ends the read: whatever was queued is discarded
                        if (!ack_ok)
                            pending_valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A load in IDLE with an empty buffer bypasses the holding register
        if (accept) begin
            if (state == IDLE && !pending_valid) begin
                shift_n = tx_data;
                state_n = SHIFT;
            end else begin
                pending_n       = tx_data;
                pending_valid_n = 1'b1;
            end
        end

        if (clear) begin
            state_n         = IDLE;
            pending_valid_n = 1'b0;
            bit_cnt_n       = '0;
            byte_sent_n     = 1'b0;
            ack_n           = 1'b0;
            nack_n          = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_tx_shifter.sv
// ============================================================================
// tb_i2c_tx_shifter : directed self-checking bench for i2c_tx_shifter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_tx_shifter;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       load_data = 1'b0;
    logic       load_ready;
    logic       falling_edge_found = 1'b0;
    logic       rising_edge_found = 1'b0;
    logic       sda_in = 1'b1;
    logic       clear = 1'b0;
    logic       tx_out;
    logic       busy;
    logic       byte_sent;
    logic       ack_received;
    logic       nack_received;

    int n_cmp = 0;
    int n_err = 0;

    i2c_tx_shifter #(.DATA_WIDTH(8)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_data            (tx_data),
        .load_data          (load_data),
        .load_ready         (load_ready),
        .falling_edge_found (falling_edge_found),
        .rising_edge_found  (rising_edge_found),
        .sda_in             (sda_in),
        .clear              (clear),
        .tx_out             (tx_out),
        .busy               (busy),
        .byte_sent          (byte_sent),
        .ack_received       (ack_received),
        .nack_received      (nack_received)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a negedge; outputs are sampled there
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_byte(input logic [7:0] d);
        load_data = 1'b1;
        tx_data   = d;
        @(negedge clk);
        load_data = 1'b0;
    endtask

    task automatic fall_pulse();
        falling_edge_found = 1'b1;
        @(negedge clk);
        falling_edge_found = 1'b0;
    endtask

    task automatic rise_pulse();
        rising_edge_found = 1'b1;
        @(negedge clk);
        rising_edge_found = 1'b0;
    endtask

    // Record the serial bit stream of one byte; returns stream, byte_sent and tx_out after bit 8
    task automatic shift_byte(input int gap, output logic [7:0] seq,
                              output logic sent, output logic rel);
        seq[7] = tx_out;
        for (int k = 1; k <= 8; k++) begin
            idle(gap);
            fall_pulse();
            if (k < 8) seq[7-k] = tx_out;
        end
        sent = byte_sent;
        rel  = tx_out;
    endtask

    logic [7:0] seq;
    logic       sent, rel;

    initial begin
        // Reset state
        idle(2);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_pulses", {byte_sent, ack_received, nack_received}, 0);
        n_rst = 1'b1;
        idle(2);

        // Single byte 0xA5, edges 10 clocks apart
        load_byte(8'hA5);
        chk("a5_busy", busy, 1);
        chk("a5_load_ready", load_ready, 1);
        shift_byte(9, seq, sent, rel);
        chk("a5_stream", seq, 8'hA5);
        chk("a5_byte_sent", sent, 1);
        chk("a5_released", rel, 1);
        idle(1);
        chk("a5_byte_sent_pulse", byte_sent, 0);

        // ACK, then release to IDLE with nothing queued
        sda_in = 1'b0;
        rise_pulse();
        chk("ack_pulse", {ack_received, nack_received}, 2'b10);
        idle(1);
        chk("ack_pulse_end", ack_received, 0);
        fall_pulse();
        chk("ack_idle_busy", busy, 0);
        chk("ack_idle_tx", tx_out, 1);

        // Back-to-back: 0x3C queued while 0xA5 shifts
        load_byte(8'hA5);
        idle(2);
        load_byte(8'h3C);
        chk("b2b_load_ready", load_ready, 0);
        chk("b2b_busy", busy, 1);
        shift_byte(2, seq, sent, rel);
        chk("b2b_stream_a5", seq, 8'hA5);
        rise_pulse();
        chk("b2b_ack", ack_received, 1);
        fall_pulse();
        chk("b2b_next_msb", tx_out, 0);
        chk("b2b_load_ready_free", load_ready, 1);
        chk("b2b_busy_kept", busy, 1);

        // NACK flushes a queued byte
        load_byte(8'h3C);
        chk("nack_pending", load_ready, 0);
        shift_byte(2, seq, sent, rel);
        chk("nack_stream_3c", seq, 8'h3C);
        sda_in = 1'b1;
        rise_pulse();
        chk("nack_pulse", {ack_received, nack_received}, 2'b01);
        fall_pulse();
        chk("nack_busy", busy, 0);
        chk("nack_load_ready", load_ready, 1);
        chk("nack_tx", tx_out, 1);
        idle(3);
        chk("nack_discarded", busy, 0);

        // clear after 3 bits of 0xF0, with a colliding load
        load_byte(8'hF0);
        repeat (3) begin
            idle(2);
            fall_pulse();
        end
        chk("clr_pre_busy", busy, 1);
        clear     = 1'b1;
        load_data = 1'b1;
        tx_data   = 8'h11;
        @(negedge clk);
        clear     = 1'b0;
        load_data = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_tx", tx_out, 1);
        chk("clr_load_ready", load_ready, 1);
        repeat (5) fall_pulse();
        chk("clr_no_byte_sent", byte_sent, 0);
        idle(2);
        chk("clr_load_dropped", busy, 0);

        // Asynchronous reset mid-byte
        sda_in = 1'b0;
        load_byte(8'h55);
        fall_pulse();
        fall_pulse();
        load_byte(8'h77);
        chk("arst_pre_tx", tx_out, 0);
        chk("arst_pre_ready", load_ready, 0);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_tx", tx_out, 1);
        chk("arst_busy", busy, 0);
        chk("arst_load_ready", load_ready, 1);
        @(negedge clk);
        n_rst = 1'b1;
        idle(1);
        load_byte(8'h80);
        shift_byte(3, seq, sent, rel);
        chk("arst_stream_80", seq, 8'h80);
        chk("arst_byte_sent", sent, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
